// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: AES ShiftRows / InvShiftRows permutation followed by a
// 2-entry in-order valid/ready buffer (1-cycle latency, 1 state/cycle).
//
// Parameters
//   NB    : state columns of 32 bits; 4, 6 or 8 (Rijndael block sizes)
//   TAG_W : width of the sideband tag carried alongside each state
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake; in_ready is purely registered
//   in_state/in_inv     : state (FIPS-197 byte order), 1 = InvShiftRows
//   in_tag              : sideband, passed through untouched
//   out_valid/out_ready : downstream handshake
//   out_state/out_tag   : oldest held entry
//   occupancy           : entries held (0..2)
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_state,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_state,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
);

  localparam int SW = 32*NB;

  // ---------------------------------------------------------------------
  // Permutation: pure wiring. Byte k = 4c+r sits at bits 8*(4*NB-1-k).
  // Forward reads column (c+s) of the same row, inverse reads (c-s).
  // ---------------------------------------------------------------------
  logic [SW-1:0] w_fwd;
  logic [SW-1:0] w_inv;
  logic [SW-1:0] w_perm;

  for (genvar r = 0; r < 4; r++) begin : g_row
    // Row offsets: (0,1,2,3) for NB=4/6, (0,1,3,4) for NB=8
    localparam int S = (r == 0) ? 0 :
                       (r == 1) ? 1 :
                       (r == 2) ? ((NB == 8) ? 3 : 2) :
                                  ((NB == 8) ? 4 : 3);
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int KO = 4*c + r;
      localparam int KF = 4*((c + S) % NB) + r;
      localparam int KI = 4*((c + NB - S) % NB) + r;
      assign w_fwd[8*(4*NB-1-KO) +: 8] = in_state[8*(4*NB-1-KF) +: 8];
      assign w_inv[8*(4*NB-1-KO) +: 8] = in_state[8*(4*NB-1-KI) +: 8];
    end
  end

  assign w_perm = in_inv ? w_inv : w_fwd;

  // ---------------------------------------------------------------------
  // 2-entry buffer. Slot 0 is always the oldest entry and drives the
  // outputs directly; slot 1 only fills when slot 0 is stalled.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [SW-1:0]      r_st0;
  logic [SW-1:0]      r_st1;
  logic [TAG_W-1:0]   r_tag0;
  logic [TAG_W-1:0]   r_tag1;

  logic w_acc;
  logic w_rel;

  assign w_acc = in_valid & r_in_ready;
  assign w_rel = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_st0       <= '0;
      r_st1       <= '0;
      r_tag0      <= '0;
      r_tag1      <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_st0       <= w_perm;
            r_tag0      <= in_tag;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_acc && w_rel) begin
            // pass-through: old head leaves, new entry becomes head
            r_st0  <= w_perm;
            r_tag0 <= in_tag;
          end else if (w_acc) begin
            r_st1      <= w_perm;
            r_tag1     <= in_tag;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_rel) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so only a release can happen
          if (w_rel) begin
            r_st0      <= r_st1;
            r_tag0     <= r_tag1;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  // Zero while reset is asserted, before the clearing edge has landed
  assign out_state = rst ? '0 : r_st0;
  assign out_tag   = rst ? '0 : r_tag0;
  assign occupancy = r_state;

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 The block SHALL have parameter NB, default 4: state columns (32-bit words); supported values 4, 6 and 8 only.
REQ-002 The block SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each state.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream presents a state.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a state this cycle.
REQ-007 The block SHALL have port in_state, input, 32*NB bits: input state.
REQ-008 The block SHALL have port in_inv, input, 1 bit: 0 selects ShiftRows, 1 selects InvShiftRows.
REQ-009 The block SHALL have port in_tag, input, TAG_W bits: sideband, passed through unchanged.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port out_state, output, 32*NB bits: shifted state.
REQ-013 The block SHALL have port out_tag, output, TAG_W bits: tag of the presented result.
REQ-014 The block SHALL have port occupancy, output, 2 bits: number of entries held (0..2).

Function
REQ-015 Byte layout SHALL be FIPS-197 big-endian: byte k = 4c+r (row r, column c) at in_state[8*(4*NB-1-k) +: 8]; out_state uses the same layout.
REQ-016 Row shift offsets s_r SHALL be (0,1,2,3) for NB=4 and NB=6, and (0,1,3,4) for NB=8.
REQ-017 Forward mode SHALL produce out[r][c] = in[r][(c+s_r) mod NB].
REQ-018 Inverse mode SHALL produce out[r][(c+s_r) mod NB] = in[r][c].
REQ-019 The permutation SHALL be applied before storage; stored entries hold the shifted state, its tag and nothing else.
REQ-020 A transfer SHALL occur on a rising edge when the corresponding valid and ready are both 1.
REQ-021 The block SHALL be a 2-entry in-order buffer with states EMPTY (occupancy 0), ONE (1) and FULL (2).
REQ-022 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it SHALL depend only on registered state, with no combinational path from out_ready.
REQ-023 out_valid SHALL be 1 in ONE and FULL; out_state and out_tag SHALL show the oldest entry.
REQ-024 Transitions SHALL be:
  - EMPTY + accept -> ONE
  - ONE + accept, no release -> FULL
  - ONE + release, no accept -> EMPTY
  - ONE + accept + release in the same cycle -> ONE, holding the new entry
  - FULL + release -> ONE
  - all other combinations hold the current state.
REQ-025 Latency SHALL be 1 cycle: a state accepted at edge N SHALL be visible with out_valid=1 after edge N; sustained throughput SHALL be 1 state per cycle when out_ready=1.
REQ-026 While out_valid=1 and out_ready=0, out_state and out_tag SHALL remain stable.
REQ-027 in_valid asserted while in_ready=0 SHALL be ignored without loss or corruption of held data.
REQ-028 Order SHALL be preserved; entries SHALL never be duplicated or dropped except by reset.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL go to EMPTY: occupancy=0, out_valid=0, in_ready=1.
REQ-030 During reset, out_state and out_tag SHALL read all-zero.
REQ-031 A reset during a transfer SHALL discard all held entries, and a simultaneous in_valid SHALL NOT be accepted.
REQ-032 The first accept after reset SHALL be possible on the first edge with rst=0.

Verification
REQ-033 NB=4, forward: in_state=00010203_04050607_08090a0b_0c0d0e0f -> out_state=00050a0f_04090e03_080d0207_0c01060b one cycle later.
REQ-034 NB=4, forward: FIPS-197 round-1 vector d42711ae_e0bf98f1_b8b45de5_1e415230 -> d4bf5d30_e0b452ae_b84111f1_1e2798e5; the same vector with in_inv=1 SHALL invert it back.
REQ-035 NB=8 (and NB=6): random states, forward then inverse -> original state restored; row 2 rotated by 3 columns for NB=8 and by 2 columns for NB=6.
REQ-036 Backpressure: out_ready=0 with tags 1,2,3 offered -> occupancy=2, in_ready=0, tag 3 held off; then out_ready=1 -> tags emerge in order 1,2,3 with stable data while stalled.
REQ-037 Streaming: in_valid=1 and out_ready=1 for 16 cycles -> 16 results on consecutive cycles, occupancy stays 1.
REQ-038 rst=1 in FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, and no stale output after reset is released.
